crc16_frame_ctrl: RTL
=====================

// Module: crc16_frame_ctrl
// PURPOSE
//  Frame-level sequencer around the 16-bit-parallel CRC-16 datapath (poly 1+x^2+x^15+x^16).
//  Sits between a 16-bit word-stream source and sink, re-seeds the CRC at every frame start,
//  and runs in one of two modes. GEN mode appends the computed CRC word after the payload.
//  CHECK mode compares the frame's final word against the CRC of the preceding words.
// PARAMETERS
//  SEED       16'hFFFF  CRC value loaded at each frame start
//  MAX_WORDS  1024      max input words per frame, incl. CRC word in CHECK mode (>=2)
//  CNT_W      11        word-counter width, >= clog2(MAX_WORDS+1)
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst        in   1   asynchronous, active-high reset
//  mode       in   1   0=GEN, 1=CHECK; sampled only on first accepted word of a frame
//  s_valid    in   1   input word valid
//  s_ready    out  1   input word accepted when s_valid&s_ready
//  s_data     in   16  input word
//  s_last     in   1   final input word of frame
//  m_valid    out  1   output word valid (registered)
//  m_ready    in   1   sink accepts when m_valid&m_ready
//  m_data     out  16  output word
//  m_last     out  1   final output word of frame
//  crc_value  out  16  CRC of the completed frame payload; held until next frame_done
//  frame_done out  1   1-cycle pulse when the frame's m_last word is accepted
//  crc_err    out  1   CHECK: mismatch on the frame; valid with frame_done, held until next
//  len_err    out  1   frame truncated at MAX_WORDS; valid with frame_done, held until next
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, m_last=0, s_ready=0 during rst, crc_value=0, frame_done=0,
//   crc_err=0, len_err=0, crc=SEED, cnt=0, state=PASS, in_frame=0.
//   A reset mid-frame discards the frame silently; no frame_done.
//  CRC next-state: crc_n = F(crc, d); F is the parallel 16-bit equation set, no reflection,
//   no final XOR, one word per clock, 0 extra latency. F(FFFF,0000)=800D; F(FFFF,FFFF)=0000.
//  Output stage: single register. s_ready = (state==PASS) & (~m_valid | m_ready).
//  FSM states:
//   PASS   : each accepted word loads the out reg (m_data=s_data), cnt++.
//            First word with in_frame=0: latch mode, use crc=SEED as base, set in_frame.
//            Non-final word: crc <= F(crc_base, s_data).
//            Final word = s_last, or cnt reaches MAX_WORDS (then len_err=1, forced last).
//            GEN final: crc_value <= F(crc_base, s_data), m_last=0, go APPEND.
//            CHECK final: word not folded into CRC; crc_err <= (s_data != crc_base);
//             crc_value <= crc_base; m_last=1; go WAIT.
//   APPEND : when out reg frees (~m_valid | m_ready): m_data=crc_value, m_last=1, go WAIT.
//            s_ready=0.
//   WAIT   : s_ready=0. On m_valid&m_ready&m_last: frame_done=1, in_frame=0, crc=SEED,
//            cnt=0, go PASS.
//  Latency: input word to m_valid is 1 clk. GEN CRC word follows last payload word with
//   no bubble when m_ready=1. Full throughput 1 word/clk within a frame.
//   1 dead cycle between frames (WAIT->PASS).
//  Backpressure: m_valid/m_data/m_last stable while m_valid & ~m_ready.
//  s_valid, s_data, s_last are don't-care while s_ready=0.
//  Single-word frame: GEN emits word + CRC. CHECK compares the word against SEED.
//  mode changes mid-frame are ignored.
//  crc_err/len_err/crc_value update at frame_done, not before; they clear only on rst.
// TESTING
//  GEN, SEED=FFFF, frame {0000,last} -> m: 0000(last=0), 800D(last=1); crc_value=800D,
//   frame_done 1 pulse.
//  GEN frame {FFFF,last}, m_ready=1 -> m: FFFF, 0000; back-to-back second frame re-seeds,
//   gives 800D for {0000}.
//  CHECK frame {0000, 800D(last)} -> m forwards both, m_last on 800D, crc_err=0.
//   {0000, 800C} -> crc_err=1.
//  m_ready toggled randomly (50%) on 64-word GEN frame -> no word lost or duplicated;
//   outputs stable while stalled; CRC equals reference model.
//  MAX_WORDS=4, GEN, 6 words without s_last -> 4 words + CRC word; len_err=1.
//   Remaining 2 words form the next frame.
//  rst asserted after 3 words of a GEN frame -> all outputs at reset values immediately;
//   next frame {0000} yields 800D.

Source files
------------

// File: rtl/crc16_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : crc16_frame_ctrl
// Purpose  : Frame sequencer around a 16-bit-parallel CRC-16 datapath
//            (poly x^16 + x^15 + x^2 + 1, 0x8005, MSB first, no reflection,
//            no final XOR).
//            GEN mode   : forwards the payload, then appends the CRC word.
//            CHECK mode : forwards the frame and compares its final word
//                         against the CRC of the preceding words.
// Ports    : clk, rst (async, active high)
//            mode                       - 0=GEN, 1=CHECK (latched per frame)
//            s_valid/s_ready/s_data/s_last - input word stream
//            m_valid/m_ready/m_data/m_last - output word stream (registered)
//            crc_value, crc_err, len_err - frame results, updated with frame_done
//            frame_done                 - 1-cycle pulse after last word leaves
// Revision : 1.0 - initial release
// ============================================================================
module crc16_frame_ctrl #(
  parameter logic [15:0] SEED      = 16'hFFFF,
  parameter int          MAX_WORDS = 1024,
  parameter int          CNT_W     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic [15:0] crc_value,
  output logic        frame_done,
  output logic        crc_err,
  output logic        len_err
);

  localparam logic [15:0]      POLY    = 16'h8005;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_PASS   = 2'd0,
    ST_APPEND = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // One full word folded per call; the loop unrolls into the parallel
  // XOR network, so there is no extra latency.
  function automatic logic [15:0] crc_next(input logic [15:0] c,
                                           input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic [15:0]       m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic [15:0]       crc_q, crc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_frame_q, in_frame_d;
  logic              mode_q, mode_d;
  // Results are staged here and only published when the frame completes.
  logic [15:0]       pend_crc_q, pend_crc_d;
  logic              pend_cerr_q, pend_cerr_d;
  logic              pend_lerr_q, pend_lerr_d;
  logic [15:0]       crc_value_q, crc_value_d;
  logic              frame_done_q, frame_done_d;
  logic              crc_err_q, crc_err_d;
  logic              len_err_q, len_err_d;

  logic              s_fire;
  logic              m_fire;
  logic              out_free;
  logic [15:0]       crc_base;
  logic              mode_eff;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hit_max;
  logic              is_final;
  logic [15:0]       crc_fold;

  always_comb begin
    out_free = ~m_valid_q | m_ready;
    // Gated by rst so the source sees no ready while reset is held.
    s_ready  = ~rst & (state_q == ST_PASS) & out_free;
    s_fire   = s_valid & s_ready;
    m_fire   = m_valid_q & m_ready;
    // First word of a frame uses the seed and the live mode input.
    crc_base = in_frame_q ? crc_q  : SEED;
    mode_eff = in_frame_q ? mode_q : mode;
    cnt_inc  = cnt_q + 1'b1;
    hit_max  = (cnt_inc == CNT_MAX);
    is_final = s_last | hit_max;
    crc_fold = crc_next(crc_base, s_data);
  end

  always_comb begin
    state_d      = state_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    in_frame_d   = in_frame_q;
    mode_d       = mode_q;
    pend_crc_d   = pend_crc_q;
    pend_cerr_d  = pend_cerr_q;
    pend_lerr_d  = pend_lerr_q;
    crc_value_d  = crc_value_q;
    frame_done_d = 1'b0;
    crc_err_d    = crc_err_q;
    len_err_d    = len_err_q;

    if (m_fire) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    unique case (state_q)
      ST_PASS: begin
        if (s_fire) begin
          m_valid_d  = 1'b1;
          m_data_d   = s_data;
          cnt_d      = cnt_inc;
          in_frame_d = 1'b1;
          mode_d     = mode_eff;
          if (!is_final) begin
            crc_d    = crc_fold;
            m_last_d = 1'b0;
          end else begin
            // A word that both carries s_last and fills the frame is a
            // normal end, not a truncation.
            pend_lerr_d = hit_max & ~s_last;
            if (!mode_eff) begin
              pend_crc_d  = crc_fold;
              pend_cerr_d = 1'b0;
              m_last_d    = 1'b0;
              state_d     = ST_APPEND;
            end else begin
              // CHECK: the final word is the received CRC, not payload.
              pend_crc_d  = crc_base;
              pend_cerr_d = (s_data != crc_base);
              m_last_d    = 1'b1;
              state_d     = ST_WAIT;
            end
          end
        end
      end

      ST_APPEND: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = pend_crc_q;
          m_last_d  = 1'b1;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (m_fire && m_last_q) begin
          frame_done_d = 1'b1;
          crc_value_d  = pend_crc_q;
          crc_err_d    = pend_cerr_q;
          len_err_d    = pend_lerr_q;
          in_frame_d   = 1'b0;
          crc_d        = SEED;
          cnt_d        = '0;
          state_d      = ST_PASS;
        end
      end

      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PASS;
      m_valid_q    <= 1'b0;
      m_data_q     <= 16'h0000;
      m_last_q     <= 1'b0;
      crc_q        <= SEED;
      cnt_q        <= '0;
      in_frame_q   <= 1'b0;
      mode_q       <= 1'b0;
      pend_crc_q   <= 16'h0000;
      pend_cerr_q  <= 1'b0;
      pend_lerr_q  <= 1'b0;
      crc_value_q  <= 16'h0000;
      frame_done_q <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      in_frame_q   <= in_frame_d;
      mode_q       <= mode_d;
      pend_crc_q   <= pend_crc_d;
      pend_cerr_q  <= pend_cerr_d;
      pend_lerr_q  <= pend_lerr_d;
      crc_value_q  <= crc_value_d;
      frame_done_q <= frame_done_d;
      crc_err_q    <= crc_err_d;
      len_err_q    <= len_err_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign crc_value  = crc_value_q;
  assign frame_done = frame_done_q;
  assign crc_err    = crc_err_q;
  assign len_err    = len_err_q;

endmodule
`default_nettype wire
